// File: rtl/mem_access_arbiter.sv
// Arbiter/sequencer for the single-port data RAM shared by instruction fetch and load/store.
// Data accesses win arbitration; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_access_arbiter #(
    parameter int RAM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [7:0]  fetch_addr,
    output logic        fetch_ack,
    output logic [31:0] fetch_data,
    input  logic        mem_req,
    input  logic        mem_rw,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        ram_en,
    output logic        ram_rw_flag,
    output logic [15:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic        owner_fetch;
    logic [3:0]  starve_cnt;
    logic [2:0]  lat_cnt;
    logic        grant_mem;
    logic        grant_fetch;

    assign grant_mem   = mem_req && (!fetch_req || (starve_cnt < 4'(STARVE_LIMIT)));
    assign grant_fetch = fetch_req && !grant_mem;
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            owner_fetch <= 1'b0;
            starve_cnt  <= '0;
            lat_cnt     <= '0;
            ram_en      <= 1'b0;
            ram_rw_flag <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            fetch_ack   <= 1'b0;
            fetch_data  <= '0;
            mem_ack     <= 1'b0;
            mem_rdata   <= '0;
        end else begin
            // Strobes are single-cycle; each state re-asserts what it needs.
            ram_en    <= 1'b0;
            fetch_ack <= 1'b0;
            mem_ack   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_mem) begin
                        owner_fetch <= 1'b0;
                        ram_addr    <= mem_addr;
                        ram_rw_flag <= mem_rw;
                        ram_wdata   <= mem_wdata;
                        ram_en      <= 1'b1;
                        state       <= S_ISSUE;
                        if (!fetch_req)
                            starve_cnt <= '0;
                        else if (starve_cnt < 4'(STARVE_LIMIT))
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (grant_fetch) begin
                        owner_fetch <= 1'b1;
                        ram_addr    <= {8'h00, fetch_addr};
                        ram_rw_flag <= 1'b0;
                        ram_en      <= 1'b1;
                        starve_cnt  <= '0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Writes complete at issue; only a data requester can write.
                    if (ram_rw_flag) begin
                        mem_ack <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        lat_cnt <= 3'd1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == 3'(RAM_LATENCY)) begin
                        lat_cnt <= '0;
                        state   <= S_RESP;
                        if (owner_fetch) begin
                            fetch_data <= ram_rdata;
                            fetch_ack  <= 1'b1;
                        end else begin
                            mem_rdata <= ram_rdata;
                            mem_ack   <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: RAM models at latency 1 and 3, ack scoreboard on the latency-1 instance.
module tb_mem_access_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // latency-1 instance
    logic        fetch_req = 1'b0, mem_req = 1'b0, mem_rw = 1'b0;
    logic [7:0]  fetch_addr = '0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        fetch_ack, mem_ack, ram_en, ram_rw_flag, busy;
    logic [31:0] fetch_data, mem_rdata, ram_wdata;
    logic [15:0] ram_addr;
    logic [31:0] ram_rdata = '0;

    // latency-3 instance (fetch only)
    logic        fetch_req3 = 1'b0;
    logic [7:0]  fetch_addr3 = '0;
    logic        fetch_ack3, mem_ack3, ram_en3, ram_rw_flag3, busy3;
    logic [31:0] fetch_data3, mem_rdata3, ram_wdata3, ram_rdata3;
    logic [15:0] ram_addr3;

    mem_access_arbiter #(.RAM_LATENCY(1), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_en(ram_en), .ram_rw_flag(ram_rw_flag), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_access_arbiter #(.RAM_LATENCY(3), .STARVE_LIMIT(3)) dut3 (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req3), .fetch_addr(fetch_addr3), .fetch_ack(fetch_ack3), .fetch_data(fetch_data3),
        .mem_req(1'b0), .mem_rw(1'b0), .mem_addr(16'h0000), .mem_wdata(32'h0),
        .mem_ack(mem_ack3), .mem_rdata(mem_rdata3),
        .ram_en(ram_en3), .ram_rw_flag(ram_rw_flag3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3), .busy(busy3)
    );

    function automatic logic [31:0] pat(input logic [15:0] a);
        return (a == 16'h002A) ? 32'hDEADBEEF : {16'hA5A5, a};
    endfunction

    // RAM model, latency 1: fixed pattern plus one writable slot
    logic        st_vld = 1'b0;
    logic [15:0] st_addr = '0;
    logic [31:0] st_data = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_rw_flag) begin
                st_vld  <= 1'b1;
                st_addr <= ram_addr;
                st_data <= ram_wdata;
            end else begin
                ram_rdata <= (st_vld && st_addr == ram_addr) ? st_data : pat(ram_addr);
            end
        end
    end

    // RAM model, latency 3: read-only pattern through a 3-deep pipe
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        if (ram_en3 && !ram_rw_flag3) p3[0] <= pat(ram_addr3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ram_rdata3 = p3[2];

    typedef struct {
        bit          is_fetch;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int errors = 0;
    int checks = 0;

    // Scoreboard monitor: every ack of the latency-1 instance pops one expectation.
    always @(negedge clk) begin
        if (fetch_ack && mem_ack) begin
            checks++; errors++;
            $display("FAIL ack_overlap fetch_ack=1 mem_ack=1 required at most one");
        end else if (fetch_ack || mem_ack) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack fetch_ack=%0b mem_ack=%0b required no ack", fetch_ack, mem_ack);
            end else begin
                e = sb.pop_front();
                if (e.is_fetch != fetch_ack) begin
                    errors++;
                    $display("FAIL ack_owner got fetch=%0b required fetch=%0b", fetch_ack, e.is_fetch);
                end else if (e.chk && ((fetch_ack ? fetch_data : mem_rdata) !== e.data)) begin
                    errors++;
                    $display("FAIL ack_data got %h required %h", fetch_ack ? fetch_data : mem_rdata, e.data);
                end
            end
        end
    end

    function automatic logic ack_of(input int sel);
        case (sel)
            0:       return fetch_ack;
            1:       return mem_ack;
            default: return fetch_ack3;
        endcase
    endfunction

    task automatic wait_ack(input int sel, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_of(sel) && n < bound);
        if (!ack_of(sel)) begin
            checks++; errors++;
            $display("FAIL ack_timeout sel=%0d waited %0d cycles required an ack", sel, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({ram_en, ram_rw_flag, fetch_ack, mem_ack, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 00000", {ram_en, ram_rw_flag, fetch_ack, mem_ack, busy});
        end
        checks++;
        if ({ram_addr, ram_wdata, fetch_data, mem_rdata} !== 112'h0) begin
            errors++;
            $display("FAIL reset_data got %h required 0", {ram_addr, ram_wdata, fetch_data, mem_rdata});
        end
        checks++;
        if ({ram_en3, ram_rw_flag3, fetch_ack3, mem_ack3, busy3, ram_addr3, ram_wdata3, fetch_data3, mem_rdata3} !== 117'h0) begin
            errors++;
            $display("FAIL reset_dut3 got nonzero outputs required 0");
        end
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        fetch_addr = 8'h2A;
        fetch_req  = 1'b1;
        sb.push_back('{is_fetch: 1'b1, chk: 1'b1, data: 32'hDEADBEEF});
        @(negedge clk); // cycle 1
        checks++;
        if ({ram_en, ram_rw_flag, busy} !== 3'b101) begin
            errors++;
            $display("FAIL fetch_issue en/rw/busy got %b required 101", {ram_en, ram_rw_flag, busy});
        end
        checks++;
        if (ram_addr !== 16'h002A) begin
            errors++;
            $display("FAIL fetch_addr got %h required 002a", ram_addr);
        end
        @(negedge clk); // cycle 2
        checks++;
        if ({ram_en, busy, fetch_ack} !== 3'b010) begin
            errors++;
            $display("FAIL fetch_wait en/busy/ack got %b required 010", {ram_en, busy, fetch_ack});
        end
        @(negedge clk); // cycle 3
        checks++;
        if ({fetch_ack, busy} !== 2'b11 || fetch_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_resp ack/busy=%b data=%h required 11 deadbeef", {fetch_ack, busy}, fetch_data);
        end
        fetch_req = 1'b0;
        @(negedge clk); // cycle 4
        checks++;
        if ({fetch_ack, busy} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_done ack/busy got %b required 00", {fetch_ack, busy});
        end
    endtask

    task automatic test_store_load();
        int n;
        mem_rw    = 1'b1;
        mem_addr  = 16'h1234;
        mem_wdata = 32'hCAFEF00D;
        mem_req   = 1'b1;
        sb.push_back('{is_fetch: 1'b0, chk: 1'b0, data: 32'h0});
        @(negedge clk); // cycle 1
        checks++;
        if ({ram_en, ram_rw_flag} !== 2'b11 || ram_addr !== 16'h1234 || ram_wdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL store_issue en/rw=%b addr=%h wdata=%h required 11 1234 cafef00d",
                     {ram_en, ram_rw_flag}, ram_addr, ram_wdata);
        end
        mem_addr  = 16'hFFFF;
        mem_wdata = 32'h0;
        @(negedge clk); // cycle 2
        checks++;
        if (mem_ack !== 1'b1 || ram_wdata !== 32'hCAFEF00D || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL store_resp ack=%b wdata=%h en=%b required 1 cafef00d 0", mem_ack, ram_wdata, ram_en);
        end
        mem_req = 1'b0;
        @(negedge clk); // cycle 3
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL store_idle busy got %b required 0", busy);
        end
        mem_rw   = 1'b0;
        mem_addr = 16'h1234;
        mem_req  = 1'b1;
        sb.push_back('{is_fetch: 1'b0, chk: 1'b1, data: 32'hCAFEF00D});
        wait_ack(1, 20, n);
        mem_req = 1'b0;
        checks++;
        if (n != 3 || mem_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL load_back latency=%0d data=%h required 3 cafef00d", n, mem_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        int got = 0;
        int n = 0;
        fetch_addr = 8'h10;
        mem_addr   = 16'h0200;
        mem_rw     = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 3; d++)
                sb.push_back('{is_fetch: 1'b0, chk: 1'b1, data: {16'hA5A5, 16'h0200}});
            sb.push_back('{is_fetch: 1'b1, chk: 1'b1, data: {16'hA5A5, 16'h0010}});
        end
        fetch_req = 1'b1;
        mem_req   = 1'b1;
        while (got < 8 && n < 80) begin
            @(negedge clk);
            n++;
            if (fetch_ack || mem_ack) got++;
        end
        fetch_req = 1'b0;
        mem_req   = 1'b0;
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL arb_ack_count got %0d required 8", got);
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL arb_drained got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        fetch_addr = 8'h00;
        fetch_req  = 1'b1;
        for (int i = 0; i < 3; i++)
            sb.push_back('{is_fetch: 1'b1, chk: 1'b1, data: {16'hA5A5, 16'(i)}});
        for (int i = 0; i < 3; i++) begin
            wait_ack(0, 20, n);
            checks++;
            if (n != ((i == 0) ? 3 : 4)) begin
                errors++;
                $display("FAIL b2b_lat1_spacing ack%0d got %0d cycles required %0d", i, n, (i == 0) ? 3 : 4);
            end
            fetch_addr = 8'(i + 1);
        end
        fetch_req = 1'b0;

        fetch_addr3 = 8'h00;
        fetch_req3  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ack(2, 20, n);
            checks++;
            if (n != ((i == 0) ? 5 : 6) || fetch_data3 !== {16'hA5A5, 16'(i)}) begin
                errors++;
                $display("FAIL b2b_lat3 ack%0d got %0d cycles data %h required %0d cycles data %h",
                         i, n, fetch_data3, (i == 0) ? 5 : 6, {16'hA5A5, 16'(i)});
            end
            fetch_addr3 = 8'(i + 1);
        end
        fetch_req3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int n;
        fetch_addr = 8'h05;
        fetch_req  = 1'b1;
        @(negedge clk); // ISSUE
        @(negedge clk); // WAIT
        checks++;
        if ({ram_en, busy} !== 2'b01) begin
            errors++;
            $display("FAIL midrd_wait en/busy got %b required 01", {ram_en, busy});
        end
        reset     = 1'b1;
        fetch_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram_en, busy, fetch_ack, mem_ack} !== 4'b0 || fetch_data !== 32'h0) begin
            errors++;
            $display("FAIL midrd_abort en/busy/acks=%b data=%h required 0000 0", {ram_en, busy, fetch_ack, mem_ack}, fetch_data);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        fetch_addr = 8'h2A;
        fetch_req  = 1'b1;
        sb.push_back('{is_fetch: 1'b1, chk: 1'b1, data: 32'hDEADBEEF});
        wait_ack(0, 20, n);
        fetch_req = 1'b0;
        checks++;
        if (n != 3 || fetch_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL midrd_after latency=%0d data=%h required 3 deadbeef", n, fetch_data);
        end
        @(negedge clk);
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({ram_en, fetch_ack, mem_ack, busy} !== 4'b0) begin
                errors++;
                $display("FAIL idle_bus cycle %0d got %b required 0000", i, {ram_en, fetch_ack, mem_ack, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_arbitration();
        test_back_to_back();
        test_reset_mid_read();
        test_idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
